// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin scheduler sharing one fancy timer among NREQ requesters.
// Serializes the 1101 start pattern plus delay onto tmr_data, waits for done, acks, pulses fin.
module timer_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] delay,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   fin,
  output logic              busy,
  output logic              err,
  output logic              tmr_data,
  output logic              tmr_ack,
  input  logic              tmr_counting,
  input  logic              tmr_done
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RUN,
    S_ACK,
    S_ERR
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] next_ptr;
  logic            win_valid;
  logic [3:0]      win_delay;
  logic [2:0]      bit_cnt;
  logic [6:0]      sreg;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First asserted request scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDXW'((32'(ptr) + k) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_delay = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_delay = delay[4*k +: 4];
      end
    end
  end

  always_comb begin
    next_ptr = (idx == IDXW'(NREQ - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      idx      <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      grant    <= '0;
      fin      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      tmr_data <= 1'b0;
      tmr_ack  <= 1'b0;
    end else begin
      fin <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            state    <= S_SEND;
            idx      <= win_idx;
            grant    <= onehot(win_idx);
            busy     <= 1'b1;
            // First pattern bit goes out with the grant; sreg holds the remaining seven.
            tmr_data <= 1'b1;
            sreg     <= {3'b101, win_delay};
            bit_cnt  <= '0;
          end
        end
        S_SEND: begin
          if (bit_cnt == 3'd7) begin
            state    <= S_RUN;
            tmr_data <= 1'b0;
          end else begin
            tmr_data <= sreg[6];
            sreg     <= {sreg[5:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        S_RUN: begin
          if (tmr_done) begin
            state   <= S_ACK;
            tmr_ack <= 1'b1;
            fin     <= onehot(idx);
          end else if (!tmr_counting) begin
            state <= S_ERR;
            err   <= 1'b1;
            fin   <= onehot(idx);
            grant <= '0;
          end
        end
        S_ACK, S_ERR: begin
          state   <= S_IDLE;
          tmr_ack <= 1'b0;
          grant   <= '0;
          busy    <= 1'b0;
          ptr     <= next_ptr;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  fin_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(fin));

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: behavioural fancy-timer model, vector table and
// scoreboard of expected job completions checked at each fin pulse.
module tb_timer_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] delay = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   fin;
  logic              busy;
  logic              err;
  logic              tmr_data;
  logic              tmr_ack;
  logic              tmr_counting;
  logic              tmr_done;
  logic              kill = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  timer_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .delay        (delay),
    .grant        (grant),
    .fin          (fin),
    .busy         (busy),
    .err          (err),
    .tmr_data     (tmr_data),
    .tmr_ack      (tmr_ack),
    .tmr_counting (tmr_counting),
    .tmr_done     (tmr_done)
  );

  // Fancy timer model; kill holds it idle so the arbiter sees neither counting nor done.
  typedef enum logic [1:0] {T_IDLE, T_DLY, T_CNT, T_DONE} tst_t;
  tst_t       ts;
  logic [3:0] sh;
  logic [3:0] dl;
  logic [1:0] nb;
  int         tcnt;

  always @(posedge clk) begin
    if (reset || kill) begin
      ts   <= T_IDLE;
      sh   <= '0;
      dl   <= '0;
      nb   <= '0;
      tcnt <= 0;
    end else begin
      case (ts)
        T_IDLE: begin
          sh <= {sh[2:0], tmr_data};
          if ({sh[2:0], tmr_data} == 4'b1101) begin
            ts <= T_DLY;
            sh <= '0;
            nb <= '0;
          end
        end
        T_DLY: begin
          dl <= {dl[2:0], tmr_data};
          nb <= nb + 2'd1;
          if (nb == 2'd3) begin
            ts   <= T_CNT;
            tcnt <= (int'({dl[2:0], tmr_data}) + 1) * 1000 - 1;
          end
        end
        T_CNT: begin
          if (tcnt == 0) ts <= T_DONE;
          else tcnt <= tcnt - 1;
        end
        default: begin
          if (tmr_ack) ts <= T_IDLE;
        end
      endcase
    end
  end

  assign tmr_counting = (ts == T_CNT);
  assign tmr_done     = (ts == T_DONE);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] fin;
    logic            ack;
    logic            err;
    logic [NREQ-1:0] grant;
    logic [7:0]      pat;
    int              count;
    int              gap;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t mk_exp(input logic [NREQ-1:0] f, input logic a, input logic e,
                                  input logic [NREQ-1:0] g, input logic [7:0] p,
                                  input int c, input int gp);
    exp_t x;
    x.fin = f; x.ack = a; x.err = e; x.grant = g; x.pat = p; x.count = c; x.gap = gp;
    return x;
  endfunction

  // Monitor: captures the serialized pattern, counting length and done timing per job.
  initial begin
    logic [NREQ-1:0] prev_grant, job_grant;
    logic [7:0]      pat;
    logic            prev_done;
    bit              in_job, grant_stable;
    int              pat_n, cnt_cnt, done_cyc, rise_cyc, last_fin_cyc;
    exp_t            e;
    prev_grant = '0; job_grant = '0; pat = '0; prev_done = 1'b0;
    in_job = 0; grant_stable = 1; pat_n = 0; cnt_cnt = 0;
    done_cyc = -1; rise_cyc = 0; last_fin_cyc = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_job = 0; prev_grant = '0; prev_done = 1'b0;
      end else begin
        chk("invariant", {29'b0, tmr_ack && (fin == '0), tmr_data && !busy, (grant != '0) && !busy}, 0);
        if (grant != '0 && prev_grant == '0) begin
          in_job = 1; job_grant = grant; rise_cyc = cyc; grant_stable = 1;
          pat = {7'b0, tmr_data}; pat_n = 1; cnt_cnt = 0; done_cyc = -1;
        end else if (in_job) begin
          if (pat_n < 8) begin
            pat = {pat[6:0], tmr_data};
            pat_n++;
          end
          if (grant != '0 && grant != job_grant) grant_stable = 0;
        end
        if (in_job && tmr_counting) cnt_cnt++;
        if (in_job && tmr_done && !prev_done) done_cyc = cyc;
        if (fin != '0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_fin", 32'(fin), 0);
          end else begin
            e = sbq.pop_front();
            chk("fin", 32'(fin), 32'(e.fin));
            chk("tmr_ack_at_fin", 32'(tmr_ack), 32'(e.ack));
            chk("err_at_fin", 32'(err), 32'(e.err));
            chk("grant_at_fin", 32'(grant), 32'(e.grant));
            chk("grant_held", 32'(grant_stable), 1);
            chk("busy_at_fin", 32'(busy), 1);
            chk("pattern", 32'(pat), 32'(e.pat));
            chk("counting_cycles", cnt_cnt, e.count);
            if (e.ack) chk("done_to_fin", cyc - done_cyc, 1);
            if (e.gap > 0) chk("gap", rise_cyc - last_fin_cyc, e.gap);
          end
          last_fin_cyc = cyc;
          in_job = 0;
        end
        prev_grant = grant;
        prev_done  = tmr_done;
      end
    end
  end

  task automatic wait_grant(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    chk({name, "_grant_timeout"}, 32'(i < 50), 1);
  endtask

  task automatic wait_fin(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fin != '0) break;
    end
    chk({name, "_fin_timeout"}, 32'(i < budget), 1);
  endtask

  task automatic reset_now(input string name);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk({name, "_outputs_zero"}, 32'({grant, fin, busy, err, tmr_data, tmr_ack}), 0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [15:0]     delay;
    logic [NREQ-1:0] grant;
    logic [7:0]      pat;
    int              count;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{4'b0001, 16'h0000, 4'b0001, 8'b1101_0000, 1000};
    vecs[1] = '{4'b0100, 16'h0F00, 4'b0100, 8'b1101_1111, 16000};
    vecs[2] = '{4'b0011, 16'h0071, 4'b0001, 8'b1101_0001, 2000};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({grant, fin, busy, err, tmr_data, tmr_ack}), 0);
    reset = 1'b0;

    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      req   = vecs[v].req;
      delay = vecs[v].delay;
      sbq.push_back(mk_exp(vecs[v].grant, 1'b1, 1'b0, vecs[v].grant, vecs[v].pat, vecs[v].count, 0));
      wait_grant("vec");
      req = '0;
      wait_fin("vec", vecs[v].count + 50);
      @(negedge clk);
      chk("vec_idle_after", 32'({grant, busy}), 0);
    end

    // Round robin with every request held high.
    @(negedge clk);
    reset_now("rr_reset");
    delay = '0;
    req   = 4'b1111;
    sbq.push_back(mk_exp(4'b0001, 1'b1, 1'b0, 4'b0001, 8'b1101_0000, 1000, 0));
    sbq.push_back(mk_exp(4'b0010, 1'b1, 1'b0, 4'b0010, 8'b1101_0000, 1000, 2));
    sbq.push_back(mk_exp(4'b0100, 1'b1, 1'b0, 4'b0100, 8'b1101_0000, 1000, 2));
    sbq.push_back(mk_exp(4'b1000, 1'b1, 1'b0, 4'b1000, 8'b1101_0000, 1000, 2));
    sbq.push_back(mk_exp(4'b0001, 1'b1, 1'b0, 4'b0001, 8'b1101_0000, 1000, 2));
    for (int k = 0; k < 5; k++) wait_fin("rr", 1100);
    req = '0;
    repeat (20) @(negedge clk);
    chk("rr_no_regrant", 32'({grant, busy}), 0);

    // Withdrawal and delay change mid-job on requester 1.
    req   = 4'b0010;
    delay = 16'h0030;
    sbq.push_back(mk_exp(4'b0010, 1'b1, 1'b0, 4'b0010, 8'b1101_0011, 4000, 0));
    wait_grant("wd");
    repeat (20) @(negedge clk);
    delay = 16'h0090;
    req   = '0;
    wait_fin("wd", 4100);
    repeat (10) @(negedge clk);
    chk("wd_no_regrant", 32'({grant, busy}), 0);

    // Protocol error: timer never starts counting.
    kill  = 1'b1;
    delay = '0;
    req   = 4'b0100;
    sbq.push_back(mk_exp(4'b0100, 1'b0, 1'b1, 4'b0000, 8'b1101_0000, 0, 0));
    wait_grant("er");
    req = '0;
    wait_fin("er", 50);
    @(negedge clk);
    chk("err_idle_next", 32'({busy, err}), 32'b01);
    kill = 1'b0;
    req  = 4'b0001;
    sbq.push_back(mk_exp(4'b0001, 1'b1, 1'b1, 4'b0001, 8'b1101_0000, 1000, 0));
    wait_grant("er2");
    req = '0;
    wait_fin("er2", 1100);
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);

    // Serve requester 2 so the pointer sits at 3 before the reset tests.
    req = 4'b0100;
    sbq.push_back(mk_exp(4'b0100, 1'b1, 1'b1, 4'b0100, 8'b1101_0000, 1000, 0));
    wait_grant("pre");
    req = '0;
    wait_fin("pre", 1100);
    @(negedge clk);

    // Reset during SEND bit 5 of a job for requester 3.
    req = 4'b1000;
    wait_grant("rs");
    repeat (5) @(negedge clk);
    reset_now("rs_send");
    req = 4'b1010;
    sbq.push_back(mk_exp(4'b0010, 1'b1, 1'b0, 4'b0010, 8'b1101_0000, 1000, 0));
    wait_grant("rs_after");
    chk("rs_first_grant", 32'(grant), 32'b0010);
    req = '0;
    wait_fin("rs_after", 1100);
    @(negedge clk);

    // Reset during RUN of a job for requester 2.
    req = 4'b0100;
    wait_grant("rr2");
    repeat (30) @(negedge clk);
    reset_now("rs_run");
    req = 4'b1010;
    sbq.push_back(mk_exp(4'b0010, 1'b1, 1'b0, 4'b0010, 8'b1101_0000, 1000, 0));
    wait_grant("rr2_after");
    chk("rr2_first_grant", 32'(grant), 32'b0010);
    req = '0;
    wait_fin("rr2_after", 1100);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
